// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared serial link constants (FSM encoding, bit order)
package serial_link_pkg;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  // Bit order agreed with the serializer: first bit on the wire is the word MSB.
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_hold_reg.sv
// rtl/sipo_hold_reg.sv - one-word output holding register with valid/ready and overrun detection
module sipo_hold_reg
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             consume;

  assign consume = valid_q & dout_ready;

  // A completing word may replace the held one only if that word leaves on the same edge.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_valid) begin
      if (!valid_q || consume) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - MSB-first serial-to-parallel deserializer with sof alignment
module sipo_deserializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;
  logic             word_done;
  logic [WIDTH-1:0] word_data;

  // Bits accumulate at the LSB end; the first bit reaches the MSB once the word is complete.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    word_done  = 1'b0;
    word_data  = {shift_q[WIDTH-2:0], sin};
    if (sin_valid) begin
      if (state_q == HUNT) begin
        if (sof) begin
          state_d = RECV;
          shift_d = {{(WIDTH-1){1'b0}}, sin};
          cnt_d   = CW'(1);
        end
      end else if (sof && (cnt_q != '0)) begin
        sync_err_d = 1'b1;
        shift_d    = {{(WIDTH-1){1'b0}}, sin};
        cnt_d      = CW'(1);
      end else if (cnt_q == LAST_BIT) begin
        word_done = 1'b1;
        shift_d   = '0;
        cnt_d     = '0;
      end else begin
        shift_d = word_data;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign sync_err = sync_err_q;

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load_valid(word_done),
    .load_data (word_data),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Receives the MSB-first serial bit stream produced by the team's PISO shifter and reassembles it into WIDTH-bit parallel words.
- A start-of-frame strobe provides word alignment.
- Completed words go to a one-word output holding register with a valid/ready handshake.
- Overrun and misalignment conditions are flagged.
- Sits directly downstream of the serializer stage on the serial link.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sof  input  1  qualifies the current bit as the first (MSB) bit of a word; ignored unless sin_valid=1.
- dout  output  WIDTH  assembled parallel word, MSB = first received bit.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- sync_err  output  1  one-cycle pulse: sof arrived while a partial word was in progress.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (async, any time, including mid-word):
  - Outputs: dout=0, dout_valid=0, overrun=0, sync_err=0, busy=0.
  - Internal: shift register=0, bit count=0, FSM=HUNT.
- FSM states:
  - HUNT: not yet aligned. Bits with sin_valid=1 and sof=0 are discarded. sin_valid=1 with sof=1 loads sin as bit WIDTH-1, sets count=1, moves to RECV.
  - RECV: aligned. On each sin_valid=1 edge the bit is shifted in (shift left, new bit at LSB) and count increments.
    - When the bit taken at count=WIDTH-1 arrives, the word is complete: {shift[WIDTH-2:0], sin}. Count returns to 0 and the FSM stays in RECV, so back-to-back words need no further sof.
  - No transition back to HUNT except via reset.
- sof in RECV:
  - With count=0: the bit is treated normally as the MSB of the next word. No error.
  - With count!=0: the partial word is discarded, sync_err pulses for one cycle, sin becomes bit WIDTH-1 of a new word, and count=1.
- sin_valid=0: no shift, no count change; gaps between bits are allowed at any point.
- Word completion latency:
  - dout and dout_valid update on the same edge that samples the final bit.
  - Both are registered, so there is no combinational path from sin to dout.
- Handshake:
  - A transfer occurs on an edge where dout_valid=1 and dout_ready=1; dout_valid then drops unless a new word completes on that same edge.
  - dout is held stable while dout_valid=1 and dout_ready=0.
  - dout_ready while dout_valid=0 is ignored.
- Simultaneous completion and consumption: if a word completes on the same edge that the held word is consumed, the new word is loaded, dout_valid stays 1, and there is no overrun.
- Overrun:
  - If a word completes while dout_valid=1 and dout_ready=0, the new word is dropped, dout is unchanged, and overrun pulses for one cycle after that edge.
  - Receive alignment is unaffected and count returns to 0.
- Pulse outputs: overrun and sync_err are registered, high for exactly one cycle per event, and both may be high in the same cycle.
- busy reflects the registered count != 0. It is 0 in HUNT.
- Bit count width: $clog2(WIDTH) bits. The count never exceeds WIDTH-1, so no wrap beyond it.

Decomposition:
- Shared package (serial_link_pkg):
  - FSM state encoding: HUNT=1'b0, RECV=1'b1.
  - The bit-order constant MSB_FIRST=1, shared with the serializer.
- Natural sub-module: sipo_hold_reg, the one-word output holding register with valid/ready, load/consume arbitration and overrun detection.
- Shift register, counter and FSM remain in the top module.

Test Plan:
- Basic word (WIDTH=8, dout_ready=1): sof with the first bit, stream 0xA5 MSB first on consecutive cycles -> dout=0xA5 and dout_valid=1 from the edge sampling bit 8, for one cycle; overrun=0, sync_err=0.
- HUNT discard: after reset, send 5 bits without sof, then sof + 0x3C -> exactly one word, 0x3C; the earlier bits have no effect.
- Gaps and back-to-back: 0x81 with sin_valid toggled every other cycle, immediately followed by 0x7E without sof -> two words, 0x81 then 0x7E, in order.
- Overrun: dout_ready=0, send 0x11 then 0x22 -> dout holds 0x11, overrun pulses once at completion of 0x22; raising dout_ready transfers 0x11, then dout_valid=0.
- Simultaneous consume: hold 0x11 with ready=0, assert ready exactly on the completion edge of 0x22 -> 0x11 consumed, dout=0x22 valid, no overrun.
- Misalign and reset: sof, 3 bits, sof + 0xC3 -> sync_err one pulse, output 0xC3. Separately, assert reset after 4 bits of a word -> all outputs 0 and HUNT; the next sof + 0x55 yields 0x55.
